// File: rtl/pcie_write_serializer_if.sv
// Message-in / RAM-write-out bundle for pcie_write_serializer.
// The master side offers messages and reports RAM backpressure; the slave side serializes.
interface pcie_write_serializer_if #(
    parameter int DATA_W = 128,
    parameter int NCHAN  = 64,
    parameter int ADDR_W = 11
);
    localparam int CHAN_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [CHAN_W-1:0] in_chan;
    logic              in_ready;
    logic              ram_busy;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_data;
    logic              ram_we;
    logic              done;

    modport master (
        output in_valid, in_data, in_chan, ram_busy,
        input  in_ready, ram_addr, ram_data, ram_we, done
    );

    modport slave (
        input  in_valid, in_data, in_chan, ram_busy,
        output in_ready, ram_addr, ram_data, ram_we, done
    );
endinterface

// File: rtl/pcie_write_serializer.sv
// Serializes a DATA_W message into 32-bit RAM writes at chan*NWORDS+k, each held WR_HOLD cycles.
// Optional macro WRSER_TOGGLE_EN stamps a per-channel toggle bit into bit 31 of the last word.
module pcie_write_serializer #(
    parameter int DATA_W  = 128,
    parameter int NCHAN   = 64,
    parameter int ADDR_W  = 11,
    parameter int WR_HOLD = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pcie_write_serializer_if.slave  bus
);
    localparam int NWORDS = DATA_W / 32;
    localparam int CHAN_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, WAIT = 2'd2} state_t;

    state_t            state_r, state_nxt_s;
    logic [IDX_W-1:0]  idx_r, idx_nxt_s;
    logic [3:0]        hold_r, hold_nxt_s;
    logic [CHAN_W-1:0] chan_r;
    logic [DATA_W-1:0] data_r, cap_data_s;
    logic [ADDR_W-1:0] ram_addr_r, addr_nxt_s;
    logic [31:0]       ram_data_r, wdata_nxt_s;
    logic              ram_we_r, we_nxt_s;
    logic              accept_s, done_s;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [CHAN_W-1:0] chan,
                                                    input logic [IDX_W-1:0]  idx);
        return ADDR_W'(chan) * ADDR_W'(NWORDS) + ADDR_W'(idx);
    endfunction

    function automatic logic [31:0] word_of(input logic [DATA_W-1:0] d,
                                            input logic [IDX_W-1:0]  idx);
        return d[{idx, 5'd0} +: 32];
    endfunction

`ifdef WRSER_TOGGLE_EN
    logic [NCHAN-1:0] tog_r;

    // Per-channel toggle flips on every accepted message of that channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tog_r <= '0;
        end else if (accept_s) begin
            tog_r[bus.in_chan] <= ~tog_r[bus.in_chan];
        end else begin
            tog_r <= tog_r;
        end
    end

    // Captured payload carries the pre-flip toggle in its top bit.
    always_comb begin
        cap_data_s = {tog_r[bus.in_chan], bus.in_data[DATA_W-2:0]};
    end
`else
    // Captured payload is the raw message.
    always_comb begin
        cap_data_s = bus.in_data;
    end
`endif

    // Next-state, next-output and done decode.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        hold_nxt_s  = hold_r;
        addr_nxt_s  = ram_addr_r;
        wdata_nxt_s = ram_data_r;
        we_nxt_s    = 1'b0;
        accept_s    = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = WRITE;
                    idx_nxt_s   = '0;
                    hold_nxt_s  = 4'd0;
                    we_nxt_s    = 1'b1;
                    addr_nxt_s  = word_addr(bus.in_chan, '0);
                    wdata_nxt_s = cap_data_s[31:0];
                end else begin
                    addr_nxt_s  = '0;
                    wdata_nxt_s = 32'd0;
                end
            end
            WRITE: begin
                if (hold_r == 4'(WR_HOLD - 1)) begin
                    state_nxt_s = WAIT;
                end else begin
                    hold_nxt_s = hold_r + 4'd1;
                    we_nxt_s   = 1'b1;
                end
            end
            WAIT: begin
                if (bus.ram_busy) begin
                    state_nxt_s = WAIT;
                end else if (idx_r == IDX_W'(NWORDS - 1)) begin
                    done_s      = 1'b1;
                    state_nxt_s = IDLE;
                    addr_nxt_s  = '0;
                    wdata_nxt_s = 32'd0;
                end else begin
                    state_nxt_s = WRITE;
                    idx_nxt_s   = idx_r + IDX_W'(1);
                    hold_nxt_s  = 4'd0;
                    we_nxt_s    = 1'b1;
                    addr_nxt_s  = word_addr(chan_r, idx_r + IDX_W'(1));
                    wdata_nxt_s = word_of(data_r, idx_r + IDX_W'(1));
                end
            end
            default: begin
                state_nxt_s = IDLE;
                addr_nxt_s  = '0;
                wdata_nxt_s = 32'd0;
            end
        endcase
    end

    // State, counters, captured message and registered RAM outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            idx_r      <= '0;
            hold_r     <= 4'd0;
            chan_r     <= '0;
            data_r     <= '0;
            ram_addr_r <= '0;
            ram_data_r <= 32'd0;
            ram_we_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            hold_r     <= hold_nxt_s;
            ram_addr_r <= addr_nxt_s;
            ram_data_r <= wdata_nxt_s;
            ram_we_r   <= we_nxt_s;
            if (accept_s) begin
                chan_r <= bus.in_chan;
                data_r <= cap_data_s;
            end else begin
                chan_r <= chan_r;
                data_r <= data_r;
            end
        end
    end

    assign bus.in_ready = (state_r == IDLE);
    assign bus.ram_addr = ram_addr_r;
    assign bus.ram_data = ram_data_r;
    assign bus.ram_we   = ram_we_r;
    assign bus.done     = done_s;
endmodule

// File: tb/tb_pcie_write_serializer.sv
// Bench for pcie_write_serializer: cycle-level message model, directed scenarios, random traffic.
module tb_pcie_write_serializer;
    localparam int DW = 128, NC = 4, AW = 11, WH = 2, NW = DW / 32;
`ifdef WRSER_TOGGLE_EN
    localparam bit TOG_EN = 1'b1;
`else
    localparam bit TOG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    pcie_write_serializer_if #(.DATA_W(DW), .NCHAN(NC), .ADDR_W(AW)) bus ();

    pcie_write_serializer #(.DATA_W(DW), .NCHAN(NC), .ADDR_W(AW), .WR_HOLD(WH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0, acc_cyc = 0, done_cyc = 0, done_cnt = 0;

    typedef struct { int addr; logic [31:0] data; int cyc; } wr_t;
    wr_t log_q[$];

    // model of the message currently being written
    bit          m_known = 0, m_active = 0;
    int          m_chan, m_k, m_pos;
    logic [31:0] m_words [NW];
    bit   [NC-1:0] m_tog;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    function automatic int find_wr(input int addr, input int nth);
        int seen = 0;
        for (int i = 0; i < log_q.size(); i++)
            if (log_q[i].addr == addr) begin
                if (seen == nth) return i;
                seen++;
            end
        return -1;
    endfunction

    // compare process: check this cycle against the model, then advance the model
    initial begin
        bit prev_we = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (m_known) begin
                if (!m_active) begin
                    chk("in_ready", {31'd0, bus.in_ready}, 32'd1);
                    chk("ram_we", {31'd0, bus.ram_we}, 32'd0);
                    chk("ram_addr", 32'(bus.ram_addr), 32'd0);
                    chk("ram_data", bus.ram_data, 32'd0);
                    chk("done", {31'd0, bus.done}, 32'd0);
                end else begin
                    chk("in_ready", {31'd0, bus.in_ready}, 32'd0);
                    chk("ram_we", {31'd0, bus.ram_we}, {31'd0, m_pos < WH});
                    chk("ram_addr", 32'(bus.ram_addr), 32'((m_chan * NW + m_k) % (1 << AW)));
                    chk("ram_data", bus.ram_data, m_words[m_k]);
                    chk("done", {31'd0, bus.done},
                        {31'd0, (m_pos == WH) && !bus.ram_busy && (m_k == NW - 1)});
                end
            end
            if (bus.ram_we && !prev_we) log_q.push_back('{int'(bus.ram_addr), bus.ram_data, cyc});
            prev_we = bus.ram_we;
            if (bus.done) begin
                done_cyc = cyc;
                done_cnt++;
            end
            if (!rst_n) begin
                m_known  = 1;
                m_active = 0;
                m_tog    = '0;
            end else if (m_known) begin
                if (!m_active) begin
                    if (bus.in_valid) begin
                        m_active = 1;
                        m_chan   = int'(bus.in_chan);
                        m_k      = 0;
                        m_pos    = 0;
                        acc_cyc  = cyc;
                        for (int i = 0; i < NW; i++) m_words[i] = bus.in_data[32*i +: 32];
                        if (TOG_EN) m_words[NW-1][31] = m_tog[m_chan];
                        m_tog[m_chan] = ~m_tog[m_chan];
                    end
                end else if (m_pos < WH) begin
                    m_pos++;
                end else if (!bus.ram_busy) begin
                    if (m_k == NW - 1) m_active = 0;
                    else begin
                        m_k++;
                        m_pos = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic [DW-1:0] d, input bit keep);
        bit ok = 0;
        bus.in_valid = 1'b1;
        bus.in_chan  = 2'(ch);
        bus.in_data  = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (bus.in_ready) ok = 1;
            tick();
        end
        chk("send_accepted", {31'd0, ok}, 32'd1);
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && !bus.in_ready; i++) tick();
        chk("wait_idle", {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic chk_word(input string name, input int addr, input int nth, input logic [31:0] exp);
        int idx = find_wr(addr, nth);
        if (idx < 0) chk({name, "_missing"}, 32'd0, 32'd1);
        else chk(name, log_q[idx].data, exp);
    endtask

    initial begin
        logic [31:0] w3_first;
        int idx, first_acc, d0;
        bus.in_valid = 1'b0;
        bus.in_chan  = '0;
        bus.in_data  = '0;
        bus.ram_busy = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_ram_we", {31'd0, bus.ram_we}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_ram_data", bus.ram_data, 32'd0);

        // basic message on channel 2
        log_q.delete();
        send(2, 128'h44444444_33333333_22222222_11111111, 1'b0);
        wait_idle();
        chk("basic_nwrites", log_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            chk("basic_addr", 32'(log_q[i].addr), 32'(8 + i));
            chk("basic_cyc", 32'(log_q[i].cyc - acc_cyc), 32'(1 + 3 * i));
        end
        chk_word("basic_w0", 8, 0, 32'h11111111);
        chk_word("basic_w1", 9, 0, 32'h22222222);
        chk_word("basic_w2", 10, 0, 32'h33333333);
        chk_word("basic_w3", 11, 0, 32'h44444444);
        chk("basic_done_lat", 32'(done_cyc - acc_cyc), 32'd12);

        // toggle: chan 1, chan 3, chan 1, all with data[127]=1
        log_q.delete();
        send(1, 128'h80000001_00000002_00000003_00000004, 1'b0);
        wait_idle();
        send(3, 128'h80000001_00000002_00000003_00000004, 1'b0);
        wait_idle();
        send(1, 128'h80000001_00000002_00000003_00000004, 1'b0);
        wait_idle();
        w3_first = TOG_EN ? 32'h00000001 : 32'h80000001;
        chk_word("tog_c1_first", 7, 0, w3_first);
        chk_word("tog_c3", 15, 0, w3_first);
        chk_word("tog_c1_second", 7, 1, 32'h80000001);
        chk_word("tog_c1_w0", 4, 0, 32'h00000004);

        // ram_busy held 5 cycles after word0 strobe
        log_q.delete();
        send(2, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        repeat (2) tick();
        bus.ram_busy = 1'b1;
        repeat (5) tick();
        bus.ram_busy = 1'b0;
        wait_idle();
        idx = find_wr(9, 0);
        if (idx < 0) chk("busy_w1_missing", 32'd0, 32'd1);
        else chk("busy_w1_start", 32'(log_q[idx].cyc - acc_cyc), 32'd9);

        // in_valid held through a message with changed data
        send(0, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        first_acc = acc_cyc;
        bus.in_data = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 40 && acc_cyc == first_acc; i++) tick();
        chk("b2b_second_acc", 32'(acc_cyc - first_acc), 32'd13);
        chk("b2b_after_done", 32'(acc_cyc - done_cyc), 32'd1);
        bus.in_valid = 1'b0;
        wait_idle();

        // reset during word2 strobe
        send(1, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        for (int i = 0; i < 40 && !(bus.ram_we && bus.ram_addr == 11'd6); i++) tick();
        chk("mid_reached_w2", {31'd0, bus.ram_we}, 32'd1);
        d0 = done_cnt;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_we_cleared", {31'd0, bus.ram_we}, 32'd0);
        chk("mid_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (15) tick();
        chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
        log_q.delete();
        send(1, 128'h80000001_00000002_00000003_00000004, 1'b0);
        wait_idle();
        chk_word("mid_tog_cleared", 7, 0, w3_first);

        // random traffic with occasional resets and backpressure
        for (int n = 0; n < 600; n++) begin
            bus.in_valid = ($urandom_range(0, 2) == 0);
            bus.in_chan  = 2'($urandom_range(0, NC - 1));
            bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
            bus.ram_busy = ($urandom_range(0, 3) == 0);
            rst_n        = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.ram_busy = 1'b0;
        wait_idle();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pcie_write_serializer.md
PCIE_WRITE_SERIALIZER -- requirements
Module: pcie_write_serializer

Interface
REQ-001 Parameter DATA_W, default 128: message width in bits; SHALL be a multiple of 32 and at least 32; NWORDS = DATA_W/32.
REQ-002 Parameter NCHAN, default 64: number of hardware-thread channels; SHALL be a power of 2; CHAN_W = clog2(NCHAN), minimum 1.
REQ-003 Parameter ADDR_W, default 11: RAM address width.
REQ-004 Parameter WR_HOLD, default 2: cycles ram_we is held per word; range 1..15.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 in_valid  input  1  message offered.
REQ-008 in_data  input  DATA_W  message payload; word k = in_data[32k+31:32k].
REQ-009 in_chan  input  CHAN_W  source thread/channel ID.
REQ-010 in_ready  output  1  block can accept a message.
REQ-011 ram_busy  input  1  RAM/PCIe side still consuming the previous write.
REQ-012 ram_addr  output  ADDR_W  write address.
REQ-013 ram_data  output  32  write data.
REQ-014 ram_we  output  1  write strobe.
REQ-015 done  output  1  one-cycle pulse when the last word of a message has been consumed.

Function
REQ-016 States SHALL be IDLE, WRITE, WAIT. IDLE: in_ready=1, ram_we=0, ram_addr=0, ram_data=0.
REQ-017 Accept occurs when in_valid && in_ready (cycle T): capture in_data, in_chan, and the channel toggle bit; clear word index and hold counter; go to WRITE.
REQ-018 in_valid while in_ready=0 SHALL be ignored; no capture, no state change.
REQ-019 WRITE: ram_we=1 for exactly WR_HOLD consecutive cycles; ram_addr and ram_data SHALL stay stable throughout; then go to WAIT.
REQ-020 ram_addr = (chan*NWORDS + k) mod 2^ADDR_W; ram_data = captured word k.
REQ-021 WAIT: ram_we=0; ram_addr and ram_data hold their last values; state is held while ram_busy=1.
REQ-022 WAIT with ram_busy=0 and k<NWORDS-1: k increments and the next cycle is WRITE.
REQ-023 WAIT with ram_busy=0 and k=NWORDS-1: done=1 in that cycle; next state is IDLE.
REQ-024 Latency: word k is strobed on cycles T+1+k(WR_HOLD+1) through T+WR_HOLD+k(WR_HOLD+1), given ram_busy=0. in_ready returns at T+1+NWORDS(WR_HOLD+1).
REQ-025 ram_busy SHALL be ignored outside WAIT; ram_busy=0 on the first WAIT cycle costs no extra cycle.
REQ-026 Per-channel toggle register tog[NCHAN]: on accept, the captured bit = tog[in_chan], and tog[in_chan] inverts in the same edge; other channels are unchanged.
REQ-027 An accept in the IDLE cycle right after done SHALL be legal (back-to-back messages).

Reset
REQ-028 rst_n=0 at a clock edge: state=IDLE, tog all 0, word index and hold counter 0; ram_we, done, ram_addr, ram_data = 0; in_ready=1 after the edge.
REQ-029 Reset mid-message SHALL abort it, with no further writes and no done pulse.

Configuration
REQ-030 Macro WRSER_TOGGLE_EN defined: bit 31 of the final word (in_data[DATA_W-1]) SHALL be replaced by the captured toggle bit, giving host-visible new-message detection.
REQ-031 WRSER_TOGGLE_EN undefined: tog registers are absent, the payload passes unmodified, and all other timing is identical.

Verification (DATA_W=128, NCHAN=4, ADDR_W=11, WR_HOLD=2, WRSER_TOGGLE_EN defined unless noted)
REQ-032 Reset, then idle 3 cycles -> in_ready=1; ram_we=0, done=0, ram_addr=0, ram_data=0.
REQ-033 Accept at T with chan=2, data=0x44444444_33333333_22222222_11111111, ram_busy=0 -> addr 8/9/10/11 with data 0x11111111/0x22222222/0x33333333/0x44444444 (bit31 forced 0); each word strobed 2 cycles, first at T+1; done at T+12; in_ready at T+13.
REQ-034 Two messages on chan 1, each data[127]=1 -> word3 bit31 = 0 then 1; a chan-3 message in between is unaffected; with macro undefined, bit31 = 1 in both.
REQ-035 ram_busy=1 for 5 cycles after word0's strobe -> ram_we stays 0 and addr stays 8 for 5 cycles; word1 strobe starts 1 cycle after ram_busy falls.
REQ-036 in_valid held high throughout a message with changed data -> ignored until in_ready; the next accept is in the cycle after done.
REQ-037 rst_n pulsed during word2's strobe -> ram_we=0 on the next cycle; no done pulse; in_ready=1; toggle state cleared (next chan-1 message bit31=0).
